jtag_multichain_player: RTL

Parametrised successor to the single-chain JTAG vector path. It drives CHAINS independent JTAG chains from one shared vector RAM with a common TCK. The divider, pass-repeat and TDO capture logic are merged into one clock domain, and an abort path is added. The block sits between the CPU-visible vector/capture RAMs and the JTAG pins. It also raises the ADC trigger at a programmable bit index.

---
 rtl/jtag_multichain_player_if.sv | 44 ++++
 rtl/jtag_multichain_player.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jtag_multichain_player_if.sv
// Signal bundle between the vector/capture RAMs, the CPU-side control and the JTAG pins.
// The player itself connects through the slave modport.
interface jtag_multichain_player_if #(
  parameter int CHAINS    = 2,
  parameter int A_WIDTH   = 12,
  parameter int DIV_WIDTH = 16,
  parameter int REP_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic [A_WIDTH-1:0]     vector_start;
  logic [A_WIDTH-1:0]     vector_end;
  logic [REP_WIDTH-1:0]   repeat_count;
  logic [DIV_WIDTH-1:0]   tck_half;
  logic [A_WIDTH-1:0]     adc_start_index;
  logic [A_WIDTH-1:0]     vec_addr;
  logic [2*CHAINS-1:0]    vec_rd_data;
  logic [A_WIDTH-1:0]     cap_addr;
  logic                   cap_we;
  logic [CHAINS-1:0]      cap_wr_data;
  logic                   tck;
  logic [CHAINS-1:0]      tms;
  logic [CHAINS-1:0]      tdi;
  logic [CHAINS-1:0]      tdo_in;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   adc_start;
  logic [REP_WIDTH-1:0]   pass_count;

  modport master (
    output start, abort, vector_start, vector_end, repeat_count, tck_half,
           adc_start_index, vec_rd_data, tdo_in,
    input  vec_addr, cap_addr, cap_we, cap_wr_data, tck, tms, tdi,
           busy, done, aborted, adc_start, pass_count
  );

  modport slave (
    input  start, abort, vector_start, vector_end, repeat_count, tck_half,
           adc_start_index, vec_rd_data, tdo_in,
    output vec_addr, cap_addr, cap_we, cap_wr_data, tck, tms, tdi,
           busy, done, aborted, adc_start, pass_count
  );
endinterface

// File: rtl/jtag_multichain_player.sv
// Plays vector RAM words onto CHAINS parallel JTAG chains with a shared TCK,
// captures TDO per bit, repeats passes and raises an ADC trigger at one address.
module jtag_multichain_player #(
  parameter int CHAINS    = 2,
  parameter int A_WIDTH   = 12,
  parameter int DIV_WIDTH = 16,
  parameter int REP_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  jtag_multichain_player_if.slave bus
);
  localparam int WORD_W = 2 * CHAINS;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_LOW, S_HIGH, S_END} state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   start_q, end_q, adc_idx_q, bit_addr;
  logic [REP_WIDTH-1:0] rep_q;
  logic [DIV_WIDTH-1:0] half_q, div_cnt;
  logic [WORD_W-1:0]    shadow_p1, next_word;
  logic                 fetch_vld_p0, fetch_vld_p1;
  logic                 cap_vld_p0;
  logic [CHAINS-1:0]    tdo_p0;
  logic [A_WIDTH-1:0]   cap_addr_p0;
  logic                 accept, kill, to_low, to_high, pass_end, div_zero;
  logic [REP_WIDTH:0]   pass_next, rep_eff;

  function automatic logic [REP_WIDTH-1:0] sat_inc(input logic [REP_WIDTH-1:0] v);
    return (&v) ? v : v + REP_WIDTH'(1);
  endfunction

  function automatic logic [A_WIDTH-1:0] next_addr(input logic [A_WIDTH-1:0] a,
                                                   input logic [A_WIDTH-1:0] last,
                                                   input logic [A_WIDTH-1:0] first);
    return (a == last) ? first : a + A_WIDTH'(1);
  endfunction

  function automatic logic [CHAINS-1:0] pick_tms(input logic [WORD_W-1:0] w);
    logic [CHAINS-1:0] r;
    for (int k = 0; k < CHAINS; k++) r[k] = w[2*k];
    return r;
  endfunction

  function automatic logic [CHAINS-1:0] pick_tdi(input logic [WORD_W-1:0] w);
    logic [CHAINS-1:0] r;
    for (int k = 0; k < CHAINS; k++) r[k] = w[2*k+1];
    return r;
  endfunction

  assign div_zero  = (div_cnt == '0);
  assign pass_next = {1'b0, bus.pass_count} + (REP_WIDTH+1)'(1);
  assign rep_eff   = (rep_q == '0) ? (REP_WIDTH+1)'(1) : {1'b0, rep_q};
  // Prefetched word arrives from RAM in the same cycle it is needed when tck_half is 0.
  assign next_word = (state_q == S_LOAD || fetch_vld_p1) ? bus.vec_rd_data : shadow_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    kill     = 1'b0;
    to_low   = 1'b0;
    to_high  = 1'b0;
    pass_end = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start && !bus.abort) begin
        state_d = S_FETCH;
        accept  = 1'b1;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_LOW;
        to_low  = 1'b1;
      end
      S_LOW: if (div_zero) begin
        state_d = S_HIGH;
        to_high = 1'b1;
      end
      S_HIGH: if (div_zero) begin
        pass_end = (bit_addr == end_q);
        if (pass_end && pass_next >= rep_eff) begin
          state_d = S_END;
        end else begin
          state_d = S_LOW;
          to_low  = 1'b1;
        end
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      kill     = 1'b1;
      to_low   = 1'b0;
      to_high  = 1'b0;
      pass_end = 1'b0;
    end
  end

  // p0: control and pin outputs; p1 flags the cycle the prefetched word is on vec_rd_data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.tck         <= 1'b0;
      bus.tms         <= '1;
      bus.tdi         <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.aborted     <= 1'b0;
      bus.adc_start   <= 1'b0;
      bus.cap_we      <= 1'b0;
      bus.vec_addr    <= '0;
      bus.cap_addr    <= '0;
      bus.cap_wr_data <= '0;
      bus.pass_count  <= '0;
      fetch_vld_p0    <= 1'b0;
      fetch_vld_p1    <= 1'b0;
      cap_vld_p0      <= 1'b0;
      div_cnt         <= '0;
    end else begin
      bus.tck       <= (state_d == S_HIGH);
      bus.busy      <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                       (state_d == S_LOW)   || (state_d == S_HIGH);
      bus.done      <= (state_d == S_END);
      bus.adc_start <= to_low && (bus.vec_addr == adc_idx_q);
      fetch_vld_p0  <= to_low;
      fetch_vld_p1  <= fetch_vld_p0;
      cap_vld_p0    <= to_high;
      bus.cap_we    <= cap_vld_p0 && !kill;
      if (cap_vld_p0) begin
        bus.cap_addr    <= cap_addr_p0;
        bus.cap_wr_data <= tdo_p0;
      end
      if (accept) begin
        bus.aborted    <= 1'b0;
        bus.pass_count <= '0;
        bus.vec_addr   <= bus.vector_start;
      end else if (kill || (state_q == S_IDLE && bus.start && bus.abort)) begin
        bus.aborted <= 1'b1;
      end
      if (pass_end) bus.pass_count <= sat_inc(bus.pass_count);
      // vec_addr always runs one bit ahead of bit_addr
      if (to_low) begin
        bus.vec_addr <= next_addr(bus.vec_addr, end_q, start_q);
        bus.tms      <= pick_tms(next_word);
        bus.tdi      <= pick_tdi(next_word);
      end
      if (to_low || to_high)  div_cnt <= half_q;
      else if (!div_zero)     div_cnt <= div_cnt - DIV_WIDTH'(1);
    end
  end

  // p0: configuration, current-bit address, TDO sample; p1: prefetch shadow
  always_ff @(posedge clk) begin
    if (accept) begin
      start_q   <= bus.vector_start;
      end_q     <= bus.vector_end;
      rep_q     <= bus.repeat_count;
      half_q    <= bus.tck_half;
      adc_idx_q <= bus.adc_start_index;
    end
    if (to_low)       bit_addr  <= bus.vec_addr;
    if (fetch_vld_p1) shadow_p1 <= bus.vec_rd_data;
    if (to_high) begin
      tdo_p0      <= bus.tdo_in;
      cap_addr_p0 <= bit_addr;
    end
  end
endmodule
